// File: rtl/hier_node_dispatch.sv
// Hierarchy node: fans one parent command out to NUM_CHILDREN channels (broadcast or sequential)
// and returns the aggregated per-child error status. Optional phase timeout: HIER_NODE_TIMEOUT_EN.
module hier_node_dispatch #(
    parameter int NUM_CHILDREN = 15,
    parameter int DATA_W       = 16,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_W-1:0]       req_data,
    input  logic                    req_mode,
    input  logic [NUM_CHILDREN-1:0] req_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [NUM_CHILDREN-1:0] rsp_status,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [NUM_CHILDREN-1:0] child_valid,
    output logic [DATA_W-1:0]       child_data,
    input  logic [NUM_CHILDREN-1:0] child_ack,
    input  logic [NUM_CHILDREN-1:0] child_err
);
    localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

    typedef enum logic [1:0] {IDLE, BCAST, SEQ, RESP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0]       data;
        logic [NUM_CHILDREN-1:0] mask;
    } cmd_t;

    state_t                  state, state_n;
    cmd_t                    cmd_q, cmd_n;
    logic [NUM_CHILDREN-1:0] pend_q, pend_n, stat_q, stat_n;
    logic [NUM_CHILDREN-1:0] sel, hit, above;
    logic [IDX_W-1:0]        idx_q, idx_n, first_idx, next_idx;
    logic                    next_found;

`ifdef HIER_NODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             tout_q, tout_n;
`endif

    assign sel = NUM_CHILDREN'(1) << idx_q;

    // Lowest requested child, and next enabled child strictly above the current index.
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        above      = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (req_mask[i]) first_idx = IDX_W'(i);
            if (IDX_W'(i) > idx_q) begin
                above[i] = 1'b1;
                if (cmd_q.mask[i]) begin
                    next_idx   = IDX_W'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        child_valid = '0;
        case (state)
            BCAST:   child_valid = pend_q;
            SEQ:     child_valid = sel;
            default: child_valid = '0;
        endcase
    end

    // Acks only count while the matching valid is high.
    assign hit = child_ack & child_valid;

    always_comb begin
        state_n   = state;
        cmd_n     = cmd_q;
        pend_n    = pend_q;
        stat_n    = stat_q;
        idx_n     = idx_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
`ifdef HIER_NODE_TIMEOUT_EN
        cnt_n     = cnt_q;
        tout_n    = tout_q;
`endif
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_n  = '{data: req_data, mask: req_mask};
                    pend_n = req_mask;
                    stat_n = '0;
                    idx_n  = first_idx;
`ifdef HIER_NODE_TIMEOUT_EN
                    cnt_n  = CNT_W'(1);
                    tout_n = 1'b0;
`endif
                    if (req_mask == '0) state_n = RESP;
                    else if (req_mode)  state_n = SEQ;
                    else                state_n = BCAST;
                end
            end
            BCAST: begin
                pend_n = pend_q & ~hit;
                stat_n = stat_q | (hit & child_err);
                if (pend_n == '0) state_n = RESP;
`ifdef HIER_NODE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    stat_n  = stat_q | (hit & child_err) | pend_n;
                    tout_n  = 1'b1;
                    state_n = RESP;
                end else cnt_n = cnt_q + CNT_W'(1);
`endif
            end
            SEQ: begin
                if (|hit) begin
                    stat_n = stat_q | (hit & child_err);
                    if (next_found) idx_n = next_idx;
                    else            state_n = RESP;
`ifdef HIER_NODE_TIMEOUT_EN
                    cnt_n = CNT_W'(1);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    stat_n  = stat_q | (cmd_q.mask & (above | sel));
                    tout_n  = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cmd_q  <= '0;
            pend_q <= '0;
            stat_q <= '0;
            idx_q  <= '0;
`ifdef HIER_NODE_TIMEOUT_EN
            cnt_q  <= '0;
            tout_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cmd_q  <= cmd_n;
            pend_q <= pend_n;
            stat_q <= stat_n;
            idx_q  <= idx_n;
`ifdef HIER_NODE_TIMEOUT_EN
            cnt_q  <= cnt_n;
            tout_q <= tout_n;
`endif
        end
    end

    assign child_data = cmd_q.data;
    assign rsp_status = (state == RESP) ? stat_q : '0;
    assign rsp_err    = |rsp_status;
`ifdef HIER_NODE_TIMEOUT_EN
    assign rsp_timeout = (state == RESP) & tout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
